vga_timing_gen: RTL and testbench

- Generates 640x480@60 VGA raster timing: horizontal/vertical pixel counters, active-low sync pulses, a display-enable flag and frame/line strobes.
- Sits directly upstream of the VGA upsampler, which consumes counterH/counterV to compute framebuffer coordinates and colour.
- Derives the pixel rate from the system clock with a clock-enable divider, not a generated clock.
- A run/drain state machine starts and stops the raster only on frame boundaries.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_timing_gen_pix_clk_div.sv | 38 +++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 raster constants and the run/drain state encoding.
// The section-boundary constants are also used by the downstream upsampler
// to map counterH/counterV onto framebuffer coordinates.
package vga_timing_pkg;

  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_H_DISP = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;
  localparam int unsigned DEF_V_DISP = 480;
  localparam int unsigned DEF_V_FP   = 10;

  localparam int unsigned H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_DISP + DEF_H_FP;
  localparam int unsigned V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_DISP + DEF_V_FP;

  localparam int unsigned H_DISP_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned H_DISP_END   = H_DISP_START + DEF_H_DISP;
  localparam int unsigned V_DISP_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned V_DISP_END   = V_DISP_START + DEF_V_DISP;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2
  } vga_state_e;

  // Counters are fixed at 10 bits; totals above 1024 are not supported.
  function automatic logic [9:0] to_cnt(input int unsigned value);
    return value[9:0];
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_div.sv
// pix_clk_div
// Clock-enable divider: a count runs 0..CLK_DIV-1 and pix_tick is a
// registered one-cycle strobe on every wrap. CLK_DIV=1 holds pix_tick high.
// Ports:
//   clk_in   - system clock
//   reset_n  - asynchronous active-low reset
//   enable   - synchronised reset release; counting starts once high
//   pix_tick - one system clock in every CLK_DIV
module pix_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic enable,
  output logic pix_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      pix_tick <= 1'b0;
    end else if (enable) begin
      if (count == LAST) begin
        count    <= '0;
        pix_tick <= 1'b1;
      end else begin
        count    <= count + CW'(1);
        pix_tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator with a run/drain controller that only starts
// and stops on frame boundaries, so downstream never sees a partial frame.
// All timing outputs are registered and decoded from the next counter
// values, keeping hsync/vsync/display_en aligned with counterH/counterV.
// Ports:
//   clk_in, reset_n  - system clock, asynchronous active-low reset
//   run              - level request to produce raster
//   pix_tick         - pixel-rate strobe; outputs update the cycle after it
//   counterH/V       - raster position
//   hsync, vsync     - active-low sync pulses
//   display_en       - high inside the active area
//   line_start       - one-clock pulse when counterH becomes 0 while running
//   frame_start      - one-clock pulse when (counterH,counterV) becomes (0,0)
//   running          - state is RUNNING or DRAINING
//
// state    | meaning
// ---------+-------------------------------------------------------------
// STOPPED  | counters held at 0, syncs inactive, no strobes
// RUNNING  | raster advances each tick; run=0 moves to DRAINING
// DRAINING | raster advances; stops after the last pixel unless run returns
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned H_DISP  = DEF_H_DISP,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned V_DISP  = DEF_V_DISP,
  parameter int unsigned V_FP    = DEF_V_FP
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       run,
  output logic       pix_tick,
  output logic [9:0] counterH,
  output logic [9:0] counterV,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam logic [9:0] H_LAST   = to_cnt(H_SYNC + H_BP + H_DISP + H_FP - 1);
  localparam logic [9:0] V_LAST   = to_cnt(V_SYNC + V_BP + V_DISP + V_FP - 1);
  localparam logic [9:0] HS_END   = to_cnt(H_SYNC);
  localparam logic [9:0] VS_END   = to_cnt(V_SYNC);
  localparam logic [9:0] HD_START = to_cnt(H_SYNC + H_BP);
  localparam logic [9:0] HD_END   = to_cnt(H_SYNC + H_BP + H_DISP);
  localparam logic [9:0] VD_START = to_cnt(V_SYNC + V_BP);
  localparam logic [9:0] VD_END   = to_cnt(V_SYNC + V_BP + V_DISP);

  // Reset asserts asynchronously everywhere; release passes through two
  // flops so the divider (and hence every state change) starts cleanly.
  logic [1:0] rst_sync;
  logic       rst_done;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_done = rst_sync[1];

  pix_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .enable   (rst_done),
    .pix_tick (pix_tick)
  );

  vga_state_e state, state_nx;
  logic [9:0] h_nx, v_nx;
  logic       hsync_nx, vsync_nx, de_nx, ls_nx, fs_nx;
  logic       h_wrap, f_wrap, active_nx;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STOPPED;
      counterH    <= '0;
      counterV    <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_en  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nx;
      counterH    <= h_nx;
      counterV    <= v_nx;
      hsync       <= hsync_nx;
      vsync       <= vsync_nx;
      display_en  <= de_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    h_nx      = counterH;
    v_nx      = counterV;
    hsync_nx  = hsync;
    vsync_nx  = vsync;
    de_nx     = display_en;
    ls_nx     = 1'b0;
    fs_nx     = 1'b0;
    h_wrap    = (counterH == H_LAST);
    f_wrap    = h_wrap && (counterV == V_LAST);
    active_nx = 1'b0;

    if (pix_tick) begin
      unique case (state)
        STOPPED: begin
          // The first running pixel is (0,0) itself, so it carries both strobes.
          if (run) begin
            state_nx = RUNNING;
            h_nx     = '0;
            v_nx     = '0;
            ls_nx    = 1'b1;
            fs_nx    = 1'b1;
          end
        end
        RUNNING, DRAINING: begin
          if (state == DRAINING && f_wrap && !run) begin
            state_nx = STOPPED;
            h_nx     = '0;
            v_nx     = '0;
          end else begin
            state_nx = run ? RUNNING : DRAINING;
            if (h_wrap) begin
              h_nx  = '0;
              ls_nx = 1'b1;
              v_nx  = (counterV == V_LAST) ? 10'd0 : counterV + 10'd1;
            end else begin
              h_nx = counterH + 10'd1;
            end
            fs_nx = f_wrap;
          end
        end
        default: begin
          state_nx = STOPPED;
          h_nx     = '0;
          v_nx     = '0;
        end
      endcase

      active_nx = (state_nx != STOPPED);
      hsync_nx  = !(active_nx && (h_nx < HS_END));
      vsync_nx  = !(active_nx && (v_nx < VS_END));
      de_nx     = active_nx &&
                  (h_nx >= HD_START) && (h_nx < HD_END) &&
                  (v_nx >= VD_START) && (v_nx < VD_END);
    end
  end

  assign running = (state != STOPPED);

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small raster: H_TOTAL=17, V_TOTAL=10, CLK_DIV=2.
  logic       rst_n, run;
  logic       pix_tick, hsync, vsync, display_en, line_start, frame_start, running;
  logic [9:0] cnt_h, cnt_v;

  // Full 640x480 raster with CLK_DIV=1.
  logic       rst1_n, run1;
  logic       pix_tick1, hsync1, vsync1, de1, ls1, fs1, running1;
  logic [9:0] cnt_h1, cnt_v1;

  int errors = 0;
  int checks = 0;

  vga_timing_gen #(
    .CLK_DIV(2), .H_SYNC(4), .H_BP(3), .H_DISP(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_DISP(5), .V_FP(1)
  ) dut (
    .clk_in(clk), .reset_n(rst_n), .run(run), .pix_tick(pix_tick),
    .counterH(cnt_h), .counterV(cnt_v), .hsync(hsync), .vsync(vsync),
    .display_en(display_en), .line_start(line_start),
    .frame_start(frame_start), .running(running)
  );

  vga_timing_gen #(
    .CLK_DIV(1)
  ) dut1 (
    .clk_in(clk), .reset_n(rst1_n), .run(run1), .pix_tick(pix_tick1),
    .counterH(cnt_h1), .counterV(cnt_v1), .hsync(hsync1), .vsync(vsync1),
    .display_en(de1), .line_start(ls1), .frame_start(fs1), .running(running1)
  );

  task automatic next_pixel();
    int n = 0;
    while (pix_tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (pix_tick !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout: pix_tick=%b after %0d clocks, required 1", pix_tick, n);
    end
    @(negedge clk);
  endtask

  task automatic goto(input logic [9:0] h, input logic [9:0] v);
    int n = 0;
    while (!(cnt_h == h && cnt_v == v) && n < 400) begin
      next_pixel();
      n++;
    end
    if (!(cnt_h == h && cnt_v == v)) begin
      checks++; errors++;
      $display("FAIL goto_timeout: at (%0d,%0d), required (%0d,%0d)", cnt_h, cnt_v, h, v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; rst1_n = 1'b0; run1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cnt_h !== 10'd0) begin errors++; $display("FAIL reset_h: got %0d, required 0", cnt_h); end
    checks++; if (cnt_v !== 10'd0) begin errors++; $display("FAIL reset_v: got %0d, required 0", cnt_v); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b, required 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b, required 1", vsync); end
    checks++; if (display_en !== 1'b0) begin errors++; $display("FAIL reset_de: got %b, required 0", display_en); end
    checks++; if (line_start !== 1'b0) begin errors++; $display("FAIL reset_ls: got %b, required 0", line_start); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
    checks++; if (pix_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, required 0", pix_tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b, required 0", running); end
  endtask

  task automatic test_start();
    int n = 0;
    run = 1'b1;
    rst_n = 1'b1;
    while (pix_tick !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (pix_tick !== 1'b1) begin errors++; $display("FAIL first_tick: got %b, required 1", pix_tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pre_tick_running: got %b, required 0", running); end
    @(negedge clk);
    checks++; if (pix_tick !== 1'b0) begin errors++; $display("FAIL tick_gap: got %b, required 0", pix_tick); end
    checks++; if (frame_start !== 1'b1 || line_start !== 1'b1) begin errors++;
      $display("FAIL first_strobes: fs=%b ls=%b, required 1 1", frame_start, line_start); end
    checks++; if (cnt_h !== 10'd0 || cnt_v !== 10'd0) begin errors++;
      $display("FAIL first_pos: (%0d,%0d), required (0,0)", cnt_h, cnt_v); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0 || display_en !== 1'b0 || running !== 1'b1) begin errors++;
      $display("FAIL first_outputs: hs=%b vs=%b de=%b run=%b, required 0 0 0 1", hsync, vsync, display_en, running); end
    @(negedge clk);
    checks++; if (pix_tick !== 1'b1 || frame_start !== 1'b0) begin errors++;
      $display("FAIL second_tick: tick=%b fs=%b, required 1 0", pix_tick, frame_start); end
    for (int i = 0; i < 16; i++) next_pixel();
    checks++; if (cnt_h !== 10'd16 || cnt_v !== 10'd0 || line_start !== 1'b0) begin errors++;
      $display("FAIL line_end: (%0d,%0d) ls=%b, required (16,0) 0", cnt_h, cnt_v, line_start); end
    next_pixel();
    checks++; if (cnt_h !== 10'd0 || cnt_v !== 10'd1 || line_start !== 1'b1 || frame_start !== 1'b0) begin errors++;
      $display("FAIL line_wrap: (%0d,%0d) ls=%b fs=%b, required (0,1) 1 0", cnt_h, cnt_v, line_start, frame_start); end
  endtask

  task automatic test_frame();
    int hs = 0, vs = 0, de = 0, ls = 0, fs = 0;
    int fh = -1, fv = -1, lh = -1, lv = -1;
    goto(10'd0, 10'd0);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_wrap_fs: got %b, required 1", frame_start); end
    for (int i = 0; i < 170; i++) begin
      if (hsync === 1'b0) hs++;
      if (vsync === 1'b0) vs++;
      if (display_en === 1'b1) begin
        de++;
        if (fh < 0) begin fh = int'(cnt_h); fv = int'(cnt_v); end
        lh = int'(cnt_h); lv = int'(cnt_v);
      end
      if (line_start === 1'b1) ls++;
      if (frame_start === 1'b1) fs++;
      next_pixel();
    end
    checks++; if (hs != 40) begin errors++; $display("FAIL hsync_low_ticks: got %0d, required 40", hs); end
    checks++; if (vs != 34) begin errors++; $display("FAIL vsync_low_ticks: got %0d, required 34", vs); end
    checks++; if (de != 40) begin errors++; $display("FAIL de_ticks: got %0d, required 40", de); end
    checks++; if (fh != 7 || fv != 4) begin errors++; $display("FAIL first_active: (%0d,%0d), required (7,4)", fh, fv); end
    checks++; if (lh != 14 || lv != 8) begin errors++; $display("FAIL last_active: (%0d,%0d), required (14,8)", lh, lv); end
    checks++; if (ls != 10 || fs != 1) begin errors++; $display("FAIL strobe_counts: ls=%0d fs=%0d, required 10 1", ls, fs); end
    checks++; if (frame_start !== 1'b1 || cnt_h !== 10'd0 || cnt_v !== 10'd0) begin errors++;
      $display("FAIL next_frame: (%0d,%0d) fs=%b, required (0,0) 1", cnt_h, cnt_v, frame_start); end
  endtask

  task automatic test_drain();
    int bad = 0, ticks = 0;
    goto(10'd5, 10'd3);
    run = 1'b0;
    next_pixel();
    checks++; if (cnt_h !== 10'd6 || cnt_v !== 10'd3 || running !== 1'b1) begin errors++;
      $display("FAIL drain_continues: (%0d,%0d) run=%b, required (6,3) 1", cnt_h, cnt_v, running); end
    goto(10'd16, 10'd9);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL drain_last_running: got %b, required 1", running); end
    next_pixel();
    checks++; if (cnt_h !== 10'd0 || cnt_v !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
                  display_en !== 1'b0 || running !== 1'b0 || frame_start !== 1'b0 || line_start !== 1'b0) begin errors++;
      $display("FAIL drain_stop: (%0d,%0d) hs=%b vs=%b de=%b run=%b fs=%b ls=%b, required (0,0) 1 1 0 0 0 0",
               cnt_h, cnt_v, hsync, vsync, display_en, running, frame_start, line_start); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pix_tick === 1'b1) ticks++;
      if (frame_start !== 1'b0 || line_start !== 1'b0 || cnt_h !== 10'd0 || cnt_v !== 10'd0 ||
          running !== 1'b0 || hsync !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stopped_quiet: %0d bad cycles, required 0", bad); end
    checks++; if (ticks != 20) begin errors++; $display("FAIL stopped_ticks: got %0d, required 20", ticks); end
    run = 1'b1;
    next_pixel();
    checks++; if (frame_start !== 1'b1 || running !== 1'b1 || cnt_h !== 10'd0 || cnt_v !== 10'd0) begin errors++;
      $display("FAIL restart: (%0d,%0d) fs=%b run=%b, required (0,0) 1 1", cnt_h, cnt_v, frame_start, running); end
  endtask

  task automatic test_rerun();
    int bad = 0, eh = 8, ev = 7;
    logic seen = 1'b0;
    goto(10'd1, 10'd1);
    run = 1'b0;
    next_pixel();
    checks++; if (cnt_h !== 10'd2 || running !== 1'b1) begin errors++;
      $display("FAIL rerun_drain: h=%0d run=%b, required 2 1", cnt_h, running); end
    goto(10'd8, 10'd7);
    run = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      next_pixel();
      eh++;
      if (eh == 17) begin eh = 0; ev = (ev == 9) ? 0 : ev + 1; end
      if (int'(cnt_h) != eh || int'(cnt_v) != ev || running !== 1'b1) bad++;
      if (frame_start === 1'b1) seen = 1'b1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rerun_continuity: %0d bad pixels, required 0", bad); end
    checks++; if (seen !== 1'b1 || cnt_h !== 10'd0 || cnt_v !== 10'd0) begin errors++;
      $display("FAIL rerun_wrap: seen=%b at (%0d,%0d), required 1 at (0,0)", seen, cnt_h, cnt_v); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    goto(10'd6, 10'd5);
    rst_n = 1'b0;
    #1;
    checks++; if (cnt_h !== 10'd0 || cnt_v !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 || display_en !== 1'b0 ||
                  running !== 1'b0 || pix_tick !== 1'b0 || frame_start !== 1'b0 || line_start !== 1'b0) begin errors++;
      $display("FAIL async_reset: (%0d,%0d) hs=%b vs=%b de=%b run=%b tick=%b, required reset values",
               cnt_h, cnt_v, hsync, vsync, display_en, running, pix_tick); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (frame_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (frame_start !== 1'b1 || line_start !== 1'b1 || cnt_h !== 10'd0 || cnt_v !== 10'd0 || running !== 1'b1) begin errors++;
      $display("FAIL reset_restart: fs=%b ls=%b (%0d,%0d) run=%b, required 1 1 (0,0) 1",
               frame_start, line_start, cnt_h, cnt_v, running); end
  endtask

  task automatic test_div1();
    int n = 0, ptbad = 0, hs = 0, de = 0, ls = 0, fsbad = 0;
    int fh = -1, fv = -1, h799 = -1, v799 = -1, h800 = -1, v800 = -1;
    rst1_n = 1'b1;
    run1 = 1'b1;
    while (fs1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (fs1 !== 1'b1) begin errors++; $display("FAIL div1_start: fs=%b, required 1", fs1); end
    for (int k = 0; k < 800 * 36; k++) begin
      if (pix_tick1 !== 1'b1) ptbad++;
      if (hsync1 === 1'b0) hs++;
      if (de1 === 1'b1) begin
        de++;
        if (fh < 0) begin fh = int'(cnt_h1); fv = int'(cnt_v1); end
      end
      if (ls1 === 1'b1) ls++;
      if (fs1 === 1'b1 && k > 0) fsbad++;
      if (k == 799) begin h799 = int'(cnt_h1); v799 = int'(cnt_v1); end
      if (k == 800) begin h800 = int'(cnt_h1); v800 = int'(cnt_v1); end
      @(negedge clk);
    end
    checks++; if (ptbad != 0) begin errors++; $display("FAIL div1_tick_const: %0d low cycles, required 0", ptbad); end
    checks++; if (h799 != 799 || v799 != 0) begin errors++; $display("FAIL div1_h_max: (%0d,%0d), required (799,0)", h799, v799); end
    checks++; if (h800 != 0 || v800 != 1) begin errors++; $display("FAIL div1_h_wrap: (%0d,%0d), required (0,1)", h800, v800); end
    checks++; if (hs != 96 * 36) begin errors++; $display("FAIL div1_hsync: got %0d, required %0d", hs, 96 * 36); end
    checks++; if (ls != 36 || fsbad != 0) begin errors++; $display("FAIL div1_strobes: ls=%0d extra_fs=%0d, required 36 0", ls, fsbad); end
    checks++; if (de != 640 || fh != 144 || fv != 35) begin errors++;
      $display("FAIL div1_first_active: de=%0d at (%0d,%0d), required 640 at (144,35)", de, fh, fv); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_frame();
    test_drain();
    test_rerun();
    test_reset_mid();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
